alu_arbiter: RTL and testbench

Shares the single-cycle `ALU` between up to NREQ requesters, such as the integer execute stage and the branch/address unit, on a round-robin basis. Each requester has its own valid/ready request and response channel. The block latches the granted operands, drives the `ALU` from registers, captures `result`/`zero` into that requester's response register and holds it until accepted. It also flags illegal control codes and counts completed operations.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_arbiter_alu.sv | 48 ++++
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared ALU opcode encoding, illegal-code boundary and the
//               arbiter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU control codes; anything above ALU_OP_MAX is reserved/illegal
    typedef enum logic [3:0] {
        ALU_ADD     = 4'b0000,
        ALU_SUB     = 4'b0001,
        ALU_AND     = 4'b0010,
        ALU_OR      = 4'b0011,
        ALU_XOR     = 4'b0100,
        ALU_SLL     = 4'b0101,
        ALU_SRL     = 4'b0110,
        ALU_SRA     = 4'b0111,
        ALU_SLT     = 4'b1000,
        ALU_SLTU    = 4'b1001,
        ALU_PASS_D2 = 4'b1010,
        ALU_PASS_D1 = 4'b1011
    } alu_op_e;

    localparam logic [3:0] ALU_OP_MAX = 4'b1011;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // True for the reserved control codes 4'b1100..4'b1111
    function automatic logic op_is_illegal(input logic [3:0] ctrl);
        return (ctrl > ALU_OP_MAX);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module      : ALU
// Description : Single-cycle combinational 32-bit integer ALU.
// Revision    : 1.0 - initial release
// Ports       : d1, d2   - 32-bit operands
//               control  - 4-bit operation code (alu_op_e)
//               result   - 32-bit operation result
//               zero     - high when result is all zeros
// ============================================================================
module ALU
    import alu_pkg::*;
(
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [3:0]  control,
    output logic [31:0] result,
    output logic        zero
);

    logic [4:0] w_shamt;

    // Shifts use only the low five bits of operand 2
    assign w_shamt = d2[4:0];

    always_comb begin
        result = '0;
        case (alu_op_e'(control))
            ALU_ADD:     result = d1 + d2;
            ALU_SUB:     result = d1 - d2;
            ALU_AND:     result = d1 & d2;
            ALU_OR:      result = d1 | d2;
            ALU_XOR:     result = d1 ^ d2;
            ALU_SLL:     result = d1 << w_shamt;
            ALU_SRL:     result = d1 >> w_shamt;
            ALU_SRA:     result = $unsigned($signed(d1) >>> w_shamt);
            ALU_SLT:     result = {31'b0, ($signed(d1) < $signed(d2))};
            ALU_SLTU:    result = {31'b0, (d1 < d2)};
            ALU_PASS_D2: result = d2;
            ALU_PASS_D1: result = d1;
            default:     result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule : ALU
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one single-cycle ALU between NREQ
//               requesters. A granted request's operands are registered,
//               executed in the following cycle and the result is held in a
//               response register until the owning requester accepts it.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n          - clock, async active-low reset
//               req_valid/req_ready - per-requester request handshake
//               req_d1/req_d2       - per-requester 32-bit operands
//               req_ctrl            - per-requester 4-bit ALU control
//               rsp_valid/rsp_ready - per-requester response handshake
//               rsp_result/zero/err - response payload of the active owner
//               busy                - operation in flight
//               ops_done            - completed response handshakes (wraps)
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][31:0]      req_d1,
    input  logic [NREQ-1:0][31:0]      req_d2,
    input  logic [NREQ-1:0][3:0]       req_ctrl,
    output logic [NREQ-1:0]            rsp_valid,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic [31:0]                rsp_result,
    output logic                       rsp_zero,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [31:0]                ops_done
);

    localparam int GW = $clog2(NREQ);

    // ------------------------------------------------------------------
    // Round-robin pick: first set bit at or after the pointer, wrapping.
    // Only meaningful when at least one valid bit is set.
    // ------------------------------------------------------------------
    function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [GW-1:0]   ptr);
        logic [GW-1:0] sel;
        logic [GW-1:0] cand;
        logic          found;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = GW'((int'(ptr) + k) % NREQ);
            if (!found && v[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        return sel;
    endfunction

    arb_state_e      r_state;
    logic [GW-1:0]   r_ptr;
    logic [GW-1:0]   r_gnt;
    logic [31:0]     r_d1;
    logic [31:0]     r_d2;
    logic [3:0]      r_ctrl;
    logic [NREQ-1:0] r_rsp_valid;
    logic [31:0]     r_result;
    logic            r_zero;
    logic            r_err;
    logic [31:0]     r_ops;

    logic            w_any;
    logic [GW-1:0]   w_pick;
    logic [NREQ-1:0] w_req_ready;
    logic [31:0]     w_alu_result;
    logic            w_alu_zero;

    assign w_any  = |req_valid;
    assign w_pick = rr_pick(req_valid, r_ptr);

    // Grant is combinational in IDLE. Gated by rst_n so the ready outputs
    // read as zero while reset is held, even with requests pending.
    always_comb begin
        w_req_ready = '0;
        if ((r_state == ST_IDLE) && rst_n && w_any) begin
            w_req_ready[w_pick] = 1'b1;
        end
    end

    ALU u_alu (
        .d1      (r_d1),
        .d2      (r_d2),
        .control (r_ctrl),
        .result  (w_alu_result),
        .zero    (w_alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_d1        <= '0;
            r_d2        <= '0;
            r_ctrl      <= '0;
            r_rsp_valid <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_err       <= 1'b0;
            r_ops       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick;
                        r_d1    <= req_d1[w_pick];
                        r_d2    <= req_d2[w_pick];
                        r_ctrl  <= req_ctrl[w_pick];
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Reserved codes override whatever the ALU produced
                    if (op_is_illegal(r_ctrl)) begin
                        r_result <= '0;
                        r_zero   <= 1'b1;
                        r_err    <= 1'b1;
                    end else begin
                        r_result <= w_alu_result;
                        r_zero   <= w_alu_zero;
                        r_err    <= 1'b0;
                    end
                    r_rsp_valid[r_gnt] <= 1'b1;
                    r_state            <= ST_RESP;
                end
                ST_RESP: begin
                    // Only the owner's ready completes the response
                    if (rsp_ready[r_gnt]) begin
                        r_rsp_valid <= '0;
                        r_ops       <= r_ops + 32'd1;
                        r_ptr       <= (r_gnt == GW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;
    assign busy       = (r_state != ST_IDLE);
    assign ops_done   = r_ops;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed, table-driven self-checking bench for alu_arbiter
//               with two requesters, plus hand-written multi-cycle sequences
//               for contention, backpressure and reset during execution.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int NREQ = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_d1;
    logic [NREQ-1:0][31:0] req_d2;
    logic [NREQ-1:0][3:0]  req_ctrl;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [31:0]           rsp_result;
    logic                  rsp_zero;
    logic                  rsp_err;
    logic                  busy;
    logic [31:0]           ops_done;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_ops  = 0;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_d1     (req_d1),
        .req_d2     (req_d2),
        .req_ctrl   (req_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        int          who;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        z;
        logic        e;
    } vec_t;

    vec_t vecs[15];

    // One isolated transaction; starts and ends just after a falling edge, DUT idle
    task automatic run_op(input int who, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [3:0] ctrl, input logic [31:0] res,
                          input logic z, input logic e);
        req_d1[who]    = d1;
        req_d2[who]    = d2;
        req_ctrl[who]  = ctrl;
        req_valid[who] = 1'b1;
        #1;
        chk("op_grant", 32'(req_ready), 32'(1 << who));
        @(negedge clk);
        req_valid[who] = 1'b0;
        #1;
        chk("op_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("op_exec_busy", 32'(busy), 32'd1);
        chk("op_exec_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("op_rsp_valid", 32'(rsp_valid), 32'(1 << who));
        chk("op_result", rsp_result, res);
        chk("op_zero", 32'(rsp_zero), 32'(z));
        chk("op_err", 32'(rsp_err), 32'(e));
        rsp_ready[who] = 1'b1;
        @(negedge clk);
        rsp_ready[who] = 1'b0;
        exp_ops++;
        #1;
        chk("op_done_valid", 32'(rsp_valid), 32'd0);
        chk("op_ops_done", ops_done, exp_ops);
        chk("op_done_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_result"}, rsp_result, 32'd0);
        chk({tag, "_zero"}, 32'(rsp_zero), 32'd0);
        chk({tag, "_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ops_done"}, ops_done, 32'd0);
    endtask

    initial begin
        int ng;
        int last;
        int gidx;
        int exp_order[4];

        vecs[0]  = '{0, 32'h10101010, 32'h01010101, 4'b0000, 32'h11111111, 1'b0, 1'b0};
        vecs[1]  = '{1, 32'h10101010, 32'h10101010, 4'b0001, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{0, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0010, 32'hF000F000, 1'b0, 1'b0};
        vecs[3]  = '{1, 32'h0F0F0000, 32'h000000F0, 4'b0011, 32'h0F0F00F0, 1'b0, 1'b0};
        vecs[4]  = '{0, 32'hFFFFFFFF, 32'h0000FFFF, 4'b0100, 32'hFFFF0000, 1'b0, 1'b0};
        vecs[5]  = '{1, 32'h00000001, 32'h0000001F, 4'b0101, 32'h80000000, 1'b0, 1'b0};
        vecs[6]  = '{0, 32'h80000000, 32'h00000004, 4'b0110, 32'h08000000, 1'b0, 1'b0};
        vecs[7]  = '{1, 32'h80000000, 32'h00000004, 4'b0111, 32'hF8000000, 1'b0, 1'b0};
        vecs[8]  = '{0, 32'hFFFFFFFF, 32'h00000001, 4'b1000, 32'h00000001, 1'b0, 1'b0};
        vecs[9]  = '{1, 32'hFFFFFFFF, 32'h00000001, 4'b1001, 32'h00000000, 1'b1, 1'b0};
        vecs[10] = '{0, 32'h00001234, 32'hCAFEBABE, 4'b1010, 32'hCAFEBABE, 1'b0, 1'b0};
        vecs[11] = '{1, 32'hDEADBEEF, 32'h00005678, 4'b1011, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[12] = '{0, 32'h00000005, 32'h00000005, 4'b1110, 32'h00000000, 1'b1, 1'b1};
        vecs[13] = '{1, 32'h00000001, 32'h00000002, 4'b1100, 32'h00000000, 1'b1, 1'b1};
        vecs[14] = '{0, 32'h00000003, 32'h00000021, 4'b0101, 32'h00000006, 1'b0, 1'b0};

        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;

        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_d1    = '0;
        req_d2    = '0;
        req_ctrl  = '0;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table of single operations ----------------
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].who, vecs[i].d1, vecs[i].d2, vecs[i].ctrl,
                   vecs[i].res, vecs[i].z, vecs[i].e);
        end

        // ---------------- backpressure on requester 0 ----------------
        req_d1[0] = 32'd1; req_d2[0] = 32'd1; req_ctrl[0] = 4'b0000;
        req_valid = 2'b01;
        rsp_ready = 2'b10;                  // requester 1 ready is not the owner
        #1;
        chk("bp_grant0", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_d1[1] = 32'd9; req_d2[1] = 32'd4; req_ctrl[1] = 4'b0001;
        req_valid = 2'b10;
        #1;
        chk("bp_exec_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_result", rsp_result, 32'd2);
            chk("bp_hold_zero", 32'(rsp_zero), 32'd0);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
            chk("bp_hold_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        exp_ops++;
        #1;
        chk("bp_after_grant1", 32'(req_ready), 32'd2);
        chk("bp_after_valid", 32'(rsp_valid), 32'd0);
        chk("bp_after_ops", ops_done, exp_ops);
        rsp_ready = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("bp_r1_valid", 32'(rsp_valid), 32'd2);
        chk("bp_r1_result", rsp_result, 32'd5);
        @(negedge clk);
        exp_ops++;
        #1;
        chk("bp_r1_done", 32'(rsp_valid), 32'd0);
        chk("bp_r1_ops", ops_done, exp_ops);
        rsp_ready = 2'b00;

        // ---------------- contention from reset ----------------
        rst_n     = 1'b0;
        exp_ops   = 0;
        req_d1[0] = 32'd3;  req_d2[0] = 32'd4;  req_ctrl[0] = 4'b0000;  // 7
        req_d1[1] = 32'h0F; req_d2[1] = 32'h03; req_ctrl[1] = 4'b0100;  // 0C
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        ng   = 0;
        last = 0;
        for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
            if (busy) chk("cont_ready_in_busy", 32'(req_ready), 32'd0);
            if (rsp_valid != 0) begin
                chk("cont_rsp_result", rsp_result, rsp_valid[0] ? 32'd7 : 32'h0C);
            end
            if (req_ready != 0) begin
                gidx = req_ready[1] ? 1 : 0;
                chk("cont_onehot", 32'($onehot(req_ready)), 32'd1);
                chk("cont_order", 32'(gidx), 32'(exp_order[ng]));
                if (ng > 0) chk("cont_spacing", 32'(cyc - last), 32'd3);
                last = cyc;
                ng++;
            end
            if (ng < 4) begin
                @(negedge clk);
                #1;
            end
        end
        chk("cont_grants", 32'(ng), 32'd4);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("cont_last_valid", 32'(rsp_valid), 32'd2);
        chk("cont_last_result", rsp_result, 32'h0C);
        @(negedge clk);
        #1;
        chk("cont_ops", ops_done, 32'd4);
        rsp_ready = 2'b00;
        exp_ops   = 4;

        // ---------------- reset during EXEC ----------------
        // Complete a requester-0 op so the pointer favours requester 1
        run_op(0, 32'd8, 32'd8, 4'b0000, 32'd16, 1'b0, 1'b0);
        req_d1[1] = 32'd1; req_d2[1] = 32'd2; req_ctrl[1] = 4'b0000;
        req_valid = 2'b10;
        #1;
        chk("rx_grant1", 32'(req_ready), 32'd2);
        @(negedge clk);
        #1;
        chk("rx_exec_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rx");
        exp_ops   = 0;
        req_d1[0] = 32'hA5A5A5A5; req_d2[0] = 32'd0; req_ctrl[0] = 4'b1011;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("rx_hold_valid", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rx_first_grant", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("rx_ops_zero", ops_done, 32'd0);
        @(negedge clk);
        #1;
        chk("rx_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rx_rsp_result", rsp_result, 32'hA5A5A5A5);
        @(negedge clk);
        #1;
        chk("rx_ops_one", ops_done, 32'd1);
        rsp_ready = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_arbiter
`default_nettype wire
